alu_sequencer: RTL

//  Issue-side master of the EX-stage ALU port (alu_op1/alu_op2/alu_op -> alu_res).

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_seq_plan.sv | 52 +++++
 rtl/alu_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU sequencer: ALU/funct3 encodings, FSM states,
// and the per-pass step descriptor produced by the pass planner.
package alu_seq_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_LTU = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;

  typedef enum logic [1:0] {SRC1_A, SRC1_B, SRC1_TMP, SRC1_A_FLIP} src1_sel_e;

  typedef enum logic [2:0] {
    SRC2_B, SRC2_SH, SRC2_ONES, SRC2_ONE, SRC2_TMP, SRC2_B_FLIP
  } src2_sel_e;

  typedef struct packed {
    logic [2:0] op;
    src1_sel_e  src1_sel;
    src2_sel_e  src2_sel;
  } step_t;

endpackage

// File: rtl/alu_seq_plan.sv
// Pass planner: maps the latched instruction and pass index to the ALU step for that
// pass, plus a flag marking the final pass of the plan.
import alu_seq_pkg::*;

module alu_seq_plan (
  input  logic [2:0] funct3_i,
  input  logic       alt_i,
  input  logic       a_msb_i,
  input  logic [1:0] pass_i,
  output step_t      step_o,
  output logic       last_o
);

  always_comb begin
    step_o = '{op: ALU_ADD, src1_sel: SRC1_A, src2_sel: SRC2_B};
    last_o = 1'b1;
    case (funct3_i)
      F3_ADD: begin
        if (alt_i) begin
          // SUB as a + ~b + 1
          last_o = (pass_i == 2'd2);
          case (pass_i)
            2'd0:    step_o = '{op: ALU_XOR, src1_sel: SRC1_B,   src2_sel: SRC2_ONES};
            2'd1:    step_o = '{op: ALU_ADD, src1_sel: SRC1_A,   src2_sel: SRC2_TMP};
            default: step_o = '{op: ALU_ADD, src1_sel: SRC1_TMP, src2_sel: SRC2_ONE};
          endcase
        end
      end
      F3_SLL:  step_o = '{op: ALU_SLL, src1_sel: SRC1_A,      src2_sel: SRC2_SH};
      F3_SLT:  step_o = '{op: ALU_LTU, src1_sel: SRC1_A_FLIP, src2_sel: SRC2_B_FLIP};
      F3_SLTU: step_o = '{op: ALU_LTU, src1_sel: SRC1_A,      src2_sel: SRC2_B};
      F3_XOR:  step_o = '{op: ALU_XOR, src1_sel: SRC1_A,      src2_sel: SRC2_B};
      F3_OR:   step_o = '{op: ALU_OR,  src1_sel: SRC1_A,      src2_sel: SRC2_B};
      F3_AND:  step_o = '{op: ALU_AND, src1_sel: SRC1_A,      src2_sel: SRC2_B};
      F3_SR: begin
        if (alt_i && a_msb_i) begin
          // Negative SRA as ~(~a >> sh)
          last_o = (pass_i == 2'd2);
          case (pass_i)
            2'd0:    step_o = '{op: ALU_XOR, src1_sel: SRC1_A,   src2_sel: SRC2_ONES};
            2'd1:    step_o = '{op: ALU_SRL, src1_sel: SRC1_TMP, src2_sel: SRC2_SH};
            default: step_o = '{op: ALU_XOR, src1_sel: SRC1_TMP, src2_sel: SRC2_ONES};
          endcase
        end else begin
          step_o = '{op: ALU_SRL, src1_sel: SRC1_A, src2_sel: SRC2_SH};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side ALU sequencer: accepts one RV32I reg-reg op, drives the external ALU for
// one to three passes, and returns the result over a valid/ready response port.
import alu_seq_pkg::*;

module alu_sequencer #(
  parameter int XLEN    = DATA_W,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_alt,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [2:0]      alu_op,
  input  logic [XLEN-1:0] alu_res,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data
);

  state_e               state_q, state_d;
  logic [2:0]           funct3_q;
  logic                 alt_q;
  logic [XLEN-1:0]      a_q, b_q, tmp_q, rsp_data_q;
  logic [SHAMT_W-1:0]   sh_q;
  logic [1:0]           pass_q;
  step_t                step;
  logic                 last_pass;
  logic                 is_cmp;

  alu_seq_plan u_plan (
    .funct3_i (funct3_q),
    .alt_i    (alt_q),
    .a_msb_i  (a_q[XLEN-1]),
    .pass_i   (pass_q),
    .step_o   (step),
    .last_o   (last_pass)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_EXEC;
      ST_EXEC: if (last_pass) state_d = ST_DONE;
      ST_DONE: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_DONE);
    alu_op    = ALU_ADD;
    alu_op1   = '0;
    alu_op2   = '0;
    if (state_q == ST_EXEC) begin
      alu_op = step.op;
      case (step.src1_sel)
        SRC1_A:      alu_op1 = a_q;
        SRC1_B:      alu_op1 = b_q;
        SRC1_TMP:    alu_op1 = tmp_q;
        SRC1_A_FLIP: alu_op1 = a_q ^ SIGN_BIT;
        default:     alu_op1 = '0;
      endcase
      case (step.src2_sel)
        SRC2_B:      alu_op2 = b_q;
        SRC2_SH:     alu_op2 = {{(XLEN-SHAMT_W){1'b0}}, sh_q};
        SRC2_ONES:   alu_op2 = ALL_ONES;
        SRC2_ONE:    alu_op2 = {{(XLEN-1){1'b0}}, 1'b1};
        SRC2_TMP:    alu_op2 = tmp_q;
        SRC2_B_FLIP: alu_op2 = b_q ^ SIGN_BIT;
        default:     alu_op2 = '0;
      endcase
    end
  end

  assign is_cmp   = (funct3_q == F3_SLT) || (funct3_q == F3_SLTU);
  assign rsp_data = rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q   <= '0;
      alt_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sh_q       <= '0;
      tmp_q      <= '0;
      pass_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        funct3_q <= req_funct3;
        alt_q    <= req_alt;
        a_q      <= req_a;
        b_q      <= req_b;
        sh_q     <= req_b[SHAMT_W-1:0];
        pass_q   <= '0;
      end
      if (state_q == ST_EXEC) begin
        tmp_q  <= alu_res;
        pass_q <= pass_q + 2'd1;
        if (last_pass) begin
          pass_q     <= '0;
          rsp_data_q <= is_cmp ? {{(XLEN-1){1'b0}}, alu_res[0]} : alu_res;
        end
      end
    end
  end

endmodule
